// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchronizer followed by a stable-count debounce FSM.
// Define DEBOUNCE_REPEAT_EN to add held-key auto-repeat (one-cycle low gap every REPEAT_CYCLES).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic busy
);

  localparam int            CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RELEASED_LVL = ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES=%0d outside 2..65535", DEBOUNCE_CYCLES);
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int            RW_BITS   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW_BITS-1:0] RCNT_LAST = RW_BITS'(REPEAT_CYCLES - 1);

  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("key_debounce: REPEAT_CYCLES=%0d must be >= 2", REPEAT_CYCLES);
  end

  typedef enum logic [2:0] {
    RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, REPEAT_GAP
  } state_t;

  logic [RW_BITS-1:0] rcnt, rcnt_n;
`else
  // REPEAT_CYCLES has no effect without auto-repeat; this empty block only references it.
  if (REPEAT_CYCLES < 0) begin : g_repeat_ignored
  end

  typedef enum logic [2:0] {
    RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT
  } state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sync1, sync2;
  logic          s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= RELEASED_LVL;
      sync2 <= RELEASED_LVL;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ ACTIVE_LOW;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
`ifdef DEBOUNCE_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CW'(1);
        end else begin
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
`ifdef DEBOUNCE_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CW'(1);
        end
`ifdef DEBOUNCE_REPEAT_EN
        else if (rcnt == RCNT_LAST) begin
          state_n = REPEAT_GAP;
          rcnt_n  = '0;
        end else begin
          rcnt_n  = rcnt + RW_BITS'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
          cnt_n   = '0;
`ifdef DEBOUNCE_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end
`ifdef DEBOUNCE_REPEAT_EN
      REPEAT_GAP: begin
        // Any release seen here is picked up on the next PRESSED cycle.
        state_n = PRESSED;
        rcnt_n  = '0;
      end
`endif
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs decode next-state so they switch on the same edge as the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RELEASED;
      cnt       <= '0;
      key_clean <= 1'b0;
      busy      <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      key_clean <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
      busy      <= (state_n == PRESS_WAIT) || (state_n == RELEASE_WAIT);
`ifdef DEBOUNCE_REPEAT_EN
      rcnt      <= rcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_CYCLES=10.
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset;
  logic key_raw;
  logic key_clean;
  logic busy;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1),
    .REPEAT_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_raw  (key_raw),
    .key_clean(key_clean),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic kc, input logic b);
    check({tag, ".key_clean"}, key_clean, kc);
    check({tag, ".busy"}, busy, b);
  endtask

  // Advance n rising edges; after each, sample 1 ns later and compare both outputs.
  task automatic run(input string tag, input int n, input logic kc, input logic b);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      expect_out(tag, kc, b);
    end
  endtask

  // Full release from PRESSED: two synchronizer edges, qualification, then released.
  task automatic release_key(input string tag);
    key_raw = 1'b1;
    run({tag, "_hold"}, 2, 1'b1, 1'b0);
    run({tag, "_qual"}, 3, 1'b1, 1'b1);
    run({tag, "_done"}, 3, 1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 1'b1;
    #2;
    reset   = 1'b0;
    #1;
    expect_out("reset_async", 1'b0, 1'b0);
    run("reset_hold", 20, 1'b0, 1'b0);
    reset = 1'b1;
    run("idle_after_reset", 20, 1'b0, 1'b0);

    // Clean press captured at edge k: busy after k+2, key_clean after k+5.
    key_raw = 1'b0;
    run("press_sync", 2, 1'b0, 1'b0);
    run("press_qual", 3, 1'b0, 1'b1);
    run("pressed", 5, 1'b1, 1'b0);

    release_key("release");

    // Press again, then a 2-sample release glitch must not drop key_clean.
    key_raw = 1'b0;
    run("press2_sync", 2, 1'b0, 1'b0);
    run("press2_qual", 3, 1'b0, 1'b1);
    run("press2_done", 1, 1'b1, 1'b0);
    key_raw = 1'b1;
    run("glitch_sync", 2, 1'b1, 1'b0);
    key_raw = 1'b0;
    run("glitch_qual", 2, 1'b1, 1'b1);
    run("glitch_back", 2, 1'b1, 1'b0);

    release_key("release2");

    // Bounce: 3 pressed samples, 1 released, then held pressed.
    key_raw = 1'b0;
    run("bounce_sync", 2, 1'b0, 1'b0);
    run("bounce_qual_a", 1, 1'b0, 1'b1);
    key_raw = 1'b1;
    run("bounce_qual_b", 1, 1'b0, 1'b1);
    key_raw = 1'b0;
    run("bounce_qual_c", 1, 1'b0, 1'b1);
    run("bounce_abort", 1, 1'b0, 1'b0);
    run("bounce_requal", 3, 1'b0, 1'b1);
    run("bounce_pressed", 1, 1'b1, 1'b0);

    release_key("release3");

    // Async reset during PRESS_WAIT with cnt=2, asserted between edges.
    key_raw = 1'b0;
    run("arst_sync", 2, 1'b0, 1'b0);
    run("arst_qual", 2, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    expect_out("arst_immediate", 1'b0, 1'b0);
    run("arst_hold", 3, 1'b0, 1'b0);
    reset = 1'b1;
    run("arst_post_sync", 2, 1'b0, 1'b0);
    run("arst_post_qual", 3, 1'b0, 1'b1);
    run("arst_post_pressed", 1, 1'b1, 1'b0);

`ifdef DEBOUNCE_REPEAT_EN
    // Held key: 10 cycles high, 1 cycle low, repeating from PRESSED entry.
    for (int i = 1; i <= 44; i++) begin
      @(posedge clk);
      #1;
      expect_out("repeat_hold", ((i % 11) != 10), 1'b0);
    end
    key_raw = 1'b1;
    run("repeat_rel_hold", 2, 1'b1, 1'b0);
    run("repeat_rel_qual", 3, 1'b1, 1'b1);
    run("repeat_released", 12, 1'b0, 1'b0);
`else
    run("hold_no_repeat", 30, 1'b1, 1'b0);
    release_key("release4");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
